// File: rtl/jtpang_rombank.sv
// Z80 ROM banking and fetch controller: NWIN banked sub-windows in 0x8000-0xBFFF,
// SDRAM fetch handshake with CPU wait and timeout. Optional one-entry cache: JTPANG_ROMBANK_CACHE_EN.
module jtpang_rombank #(
  parameter int ROM_AW    = 20,
  parameter int BANKW     = 4,
  parameter int NWIN      = 2,
  parameter int BANK_OFS  = 2,
  parameter int BANK_PORT = 2,
  parameter int TMO       = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            A,
  input  logic                   mreq_n,
  input  logic                   iorq_n,
  input  logic                   rfsh_n,
  input  logic                   wr_n,
  input  logic                   rd_n,
  input  logic [7:0]             cpu_dout,
  output logic [ROM_AW-1:0]      rom_addr,
  output logic                   rom_cs,
  input  logic [7:0]             rom_data,
  input  logic                   rom_ok,
  output logic [7:0]             dout,
  output logic                   wait_n,
  output logic                   tmo_err,
  output logic [NWIN*BANKW-1:0]  banks
);

  localparam int          WIW   = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int          WAW   = 14 - $clog2(NWIN);
  localparam int          CW    = $clog2(TMO + 1);
  localparam logic [13:0] WMASK = 14'((32'd1 << WAW) - 32'd1);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, VALID = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [BANKW-1:0]  bank_q [NWIN];
  logic [BANKW-1:0]  bank_d [NWIN];
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic              cs_q, cs_d;
  logic [7:0]        dout_q, dout_d;
  logic              tmo_q, tmo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [15:0]       a_q, a_d;
  logic              romsel, bank_wr, wait_low;
  logic [WIW-1:0]    win;
  logic [ROM_AW-1:0] page, addr_calc;
`ifdef JTPANG_ROMBANK_CACHE_EN
  logic              cvld_q, cvld_d;
  logic [ROM_AW-1:0] caddr_q, caddr_d;
  logic [7:0]        cdata_q, cdata_d;
  logic              cache_hit;
`endif

  // rd_n and the data bits above the bank width play no part in decode
  logic unused_ok;
  assign unused_ok = ^{rd_n, cpu_dout[7:BANKW]};

  assign romsel   = !mreq_n && rfsh_n && (A[15:14] != 2'b11);
  assign rom_addr = addr_q;
  assign rom_cs   = cs_q;
  assign dout     = dout_q;
  assign tmo_err  = tmo_q;
  assign wait_n   = rst | ~wait_low;

  always_comb begin
    win  = (NWIN > 1) ? WIW'(A[13:0] >> WAW) : '0;
    page = ROM_AW'(bank_q[win]) + ROM_AW'(BANK_OFS);
    if (!A[15]) addr_calc = ROM_AW'(A[14:0]);
    else        addr_calc = (page << WAW) | ROM_AW'(A[13:0] & WMASK);
    bank_wr = 1'b0;
    for (int i = 0; i < NWIN; i++) begin
      bank_d[i] = bank_q[i];
      if (!iorq_n && !wr_n && A[4:0] == 5'(BANK_PORT + i)) begin
        bank_d[i] = cpu_dout[BANKW-1:0];
        bank_wr   = 1'b1;
      end else begin
        bank_d[i] = bank_q[i];
      end
    end
    for (int i = 0; i < NWIN; i++) banks[i*BANKW +: BANKW] = bank_q[i];
  end

`ifdef JTPANG_ROMBANK_CACHE_EN
  assign cache_hit = cvld_q && (caddr_q == addr_calc);
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cs_d     = cs_q;
    dout_d   = dout_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    wait_low = 1'b0;
`ifdef JTPANG_ROMBANK_CACHE_EN
    cvld_d   = cvld_q;
    caddr_d  = caddr_q;
    cdata_d  = cdata_q;
`endif
    case (state_q)
      IDLE: begin
        if (romsel) begin
          a_d = A;
`ifdef JTPANG_ROMBANK_CACHE_EN
          if (cache_hit) begin
            dout_d  = cdata_q;
            state_d = VALID;
          end else begin
`endif
            addr_d   = addr_calc;
            cs_d     = 1'b1;
            cnt_d    = '0;
            wait_low = 1'b1;
            state_d  = FETCH;
`ifdef JTPANG_ROMBANK_CACHE_EN
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        // cnt_q==0 marks the first FETCH cycle, where rom_ok may still be stale
        if (mreq_n) begin
          cs_d    = 1'b0;
          state_d = IDLE;
        end else if (cnt_q != '0 && rom_ok) begin
          dout_d  = rom_data;
          cs_d    = 1'b0;
          state_d = VALID;
`ifdef JTPANG_ROMBANK_CACHE_EN
          cvld_d  = 1'b1;
          caddr_d = addr_q;
          cdata_d = rom_data;
`endif
        end else if (cnt_q + CW'(1) == CW'(TMO)) begin
          dout_d  = 8'hFF;
          tmo_d   = 1'b1;
          cs_d    = 1'b0;
          state_d = VALID;
`ifdef JTPANG_ROMBANK_CACHE_EN
          cvld_d  = 1'b0;
`endif
        end else begin
          cnt_d    = cnt_q + CW'(1);
          wait_low = 1'b1;
        end
      end
      VALID: begin
        if (mreq_n || !romsel || A != a_q) state_d = IDLE;
        else                               state_d = VALID;
      end
      default: begin
        cs_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
`ifdef JTPANG_ROMBANK_CACHE_EN
    cvld_d = cvld_d & ~bank_wr;
`endif
  end

  // state, bank and fetch registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < NWIN; i++) bank_q[i] <= '0;
      addr_q  <= '0;
      cs_q    <= 1'b0;
      dout_q  <= 8'hFF;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= 16'h0000;
`ifdef JTPANG_ROMBANK_CACHE_EN
      cvld_q  <= 1'b0;
      caddr_q <= '0;
      cdata_q <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NWIN; i++) bank_q[i] <= bank_d[i];
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      dout_q  <= dout_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
`ifdef JTPANG_ROMBANK_CACHE_EN
      cvld_q  <= cvld_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
`endif
    end
  end

endmodule

// File: tb/tb_jtpang_rombank.sv
// Self-checking bench for jtpang_rombank: directed steps plus random accesses against a
// behavioural model of banking, fetch latency, timeout and (when enabled) the cache.
module tb_jtpang_rombank;
  localparam int ROM_AW = 20, BANKW = 4, NWIN = 2, BANK_OFS = 2, BANK_PORT = 2, TMO = 255;

  logic clk = 1'b0;
  logic rst, mreq_n, iorq_n, rfsh_n, wr_n, rd_n, rom_cs, rom_ok, wait_n, tmo_err;
  logic [15:0] A;
  logic [7:0]  cpu_dout, rom_data, dout;
  logic [ROM_AW-1:0] rom_addr;
  logic [NWIN*BANKW-1:0] banks;

  jtpang_rombank #(.ROM_AW(ROM_AW), .BANKW(BANKW), .NWIN(NWIN), .BANK_OFS(BANK_OFS),
                   .BANK_PORT(BANK_PORT), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .A(A), .mreq_n(mreq_n), .iorq_n(iorq_n), .rfsh_n(rfsh_n),
    .wr_n(wr_n), .rd_n(rd_n), .cpu_dout(cpu_dout), .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_data(rom_data), .rom_ok(rom_ok), .dout(dout), .wait_n(wait_n),
    .tmo_err(tmo_err), .banks(banks));

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  int bank_m [NWIN];
  logic [7:0] dout_m, cdata_m;
  bit tmo_m, cv_m;
  int caddr_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NWIN; i++) bank_m[i] = 0;
    dout_m = 8'hFF; tmo_m = 1'b0; cv_m = 1'b0; caddr_m = 0; cdata_m = 8'h00;
  endtask

  function automatic int exp_addr(input int a);
    int ws, w;
    ws = 16384 / NWIN;
    if (a < 32768) return a;
    w = (a - 32768) / ws;
    return ((bank_m[w] + BANK_OFS) * ws + (a % ws)) % (1 << ROM_AW);
  endfunction

  function automatic int banks_m();
    int r = 0;
    for (int i = 0; i < NWIN; i++) r += bank_m[i] * (1 << (i * BANKW));
    return r;
  endfunction

  task automatic io_write(input int port, input int d);
    @(posedge clk); #1;
    A = 16'(port); cpu_dout = 8'(d); iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    iorq_n = 1'b1; wr_n = 1'b1;
    if (port >= BANK_PORT && port < BANK_PORT + NWIN) begin
      bank_m[port - BANK_PORT] = d % (1 << BANKW);
      cv_m = 1'b0;
    end
    @(negedge clk);
    check("banks", 32'(banks), 32'(banks_m()));
  endtask

  // dly: FETCH cycles after rom_cs before rom_ok rises (0 = rom_ok already high)
  task automatic rom_read(input logic [15:0] a, input int dly, input logic [7:0] d,
                          output logic [ROM_AW-1:0] got_addr);
    int ea, idx, exp_lows, lows, j;
    bit hit, to, done;
    ea  = exp_addr(int'(a));
    hit = 1'b0;
`ifdef JTPANG_ROMBANK_CACHE_EN
    hit = cv_m && (caddr_m == ea);
`endif
    idx = (dly + 1 > 2) ? dly + 1 : 2;
    to  = !hit && (idx > TMO);
    exp_lows = hit ? 0 : (to ? TMO : idx);
    got_addr = '0;
    @(posedge clk); #1;
    A = a; mreq_n = 1'b0; rd_n = 1'b0; rom_data = d; rom_ok = (dly == 0);
    lows = 0; j = 0; done = 1'b0;
    @(negedge clk);
    if (!wait_n) lows++;
    if (hit) check("hit_rom_cs", 32'(rom_cs), 32'd0);
    else begin
      while (!done && j < 400) begin
        @(posedge clk); #1;
        j++;
        rom_ok = (j >= dly + 1);
        @(negedge clk);
        if (j == 1) begin
          got_addr = rom_addr;
          check("fetch_rom_cs", 32'(rom_cs), 32'd1);
          check("fetch_rom_addr", 32'(rom_addr), 32'(ea));
        end
        if (wait_n) done = 1'b1;
        else lows++;
      end
      check("fetch_done_in_budget", 32'(done), 32'd1);
    end
    check("wait_cycles", 32'(lows), 32'(exp_lows));
    if (hit) dout_m = cdata_m;
    else if (to) begin dout_m = 8'hFF; tmo_m = 1'b1; cv_m = 1'b0; end
    else begin dout_m = d; cv_m = 1'b1; caddr_m = ea; cdata_m = d; end
    @(posedge clk); #1;
    rom_ok = 1'b0;
    @(negedge clk);
    check("valid_dout", 32'(dout), 32'(dout_m));
    check("valid_tmo_err", 32'(tmo_err), 32'(tmo_m));
    check("valid_wait_n", 32'(wait_n), 32'd1);
    check("valid_rom_cs", 32'(rom_cs), 32'd0);
    @(posedge clk); #1;
    mreq_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic no_rom(input logic [15:0] a, input logic rf);
    @(posedge clk); #1;
    A = a; mreq_n = 1'b0; rfsh_n = rf;
    @(negedge clk);
    check("norom_wait_n", 32'(wait_n), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("norom_rom_cs", 32'(rom_cs), 32'd0);
    @(posedge clk); #1;
    mreq_n = 1'b1; rfsh_n = 1'b1;
  endtask

  initial begin
    logic [ROM_AW-1:0] ga;
    logic [15:0] last_a;
    logic [7:0] prev, nb;
    int e0;
    rst = 1'b1; A = 16'h0000; mreq_n = 1'b1; iorq_n = 1'b1; rfsh_n = 1'b1;
    wr_n = 1'b1; rd_n = 1'b1; cpu_dout = 8'h00; rom_data = 8'h00; rom_ok = 1'b0;
    reset_model();
    #2;
    check("rst_rom_cs", 32'(rom_cs), 32'd0);
    check("rst_wait_n", 32'(wait_n), 32'd1);
    check("rst_dout", 32'(dout), 32'hFF);
    check("rst_tmo_err", 32'(tmo_err), 32'd0);
    check("rst_banks", 32'(banks), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    io_write(2, 3);
    io_write(3, 5);
    check("banks_53", 32'(banks), 32'h53);
    rom_read(16'h8010, 1, 8'h3C, ga);
    check("win0_addr", 32'(ga), 32'h0A010);
    rom_read(16'hA010, 2, 8'hC3, ga);
    check("win1_addr", 32'(ga), 32'h0E010);
    rom_read(16'h4123, 3, 8'hA5, ga);
    check("fixed_addr", 32'(ga), 32'h04123);
    rom_read(16'h0200, 0, 8'h11, ga);

    rom_read(16'h8000, 1, 8'h77, ga);
    rom_read(16'h8000, 1, 8'h99, ga);
    io_write(2, 4);
    rom_read(16'h8000, 1, 8'h42, ga);

    // abort mid-FETCH
    prev = dout_m;
    @(posedge clk); #1; A = 16'h8102; mreq_n = 1'b0; rd_n = 1'b0; rom_ok = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    mreq_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
    check("abort_wait_n", 32'(wait_n), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_rom_cs", 32'(rom_cs), 32'd0);
    check("abort_dout", 32'(dout), 32'(prev));

    // bank write during FETCH: in-flight address held, next access uses new bank
    e0 = exp_addr(32'h8002);
    nb = 8'((bank_m[0] + 7) % 16);
    @(posedge clk); #1; A = 16'h8002; mreq_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); #1; iorq_n = 1'b0; wr_n = 1'b0; cpu_dout = nb;
    @(posedge clk); #1; iorq_n = 1'b1; wr_n = 1'b1;
    bank_m[0] = int'(nb); cv_m = 1'b0;
    @(negedge clk);
    check("inflight_addr", 32'(rom_addr), 32'(e0));
    check("inflight_banks", 32'(banks), 32'(banks_m()));
    rom_ok = 1'b1; rom_data = 8'h6B;
    @(posedge clk); #1; rom_ok = 1'b0;
    @(negedge clk);
    check("inflight_dout", 32'(dout), 32'h6B);
    dout_m = 8'h6B; cv_m = 1'b1; caddr_m = e0; cdata_m = 8'h6B;
    @(posedge clk); #1; mreq_n = 1'b1; rd_n = 1'b1;
    rom_read(16'h8002, 1, 8'h5A, ga);

    no_rom(16'hC123, 1'b1);
    no_rom(16'h8010, 1'b0);

    last_a = 16'h0000;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) io_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      else begin
        logic [15:0] ra;
        ra = ($urandom_range(0, 3) == 0) ? last_a : 16'($urandom_range(0, 16'hBFFF));
        last_a = ra;
        rom_read(ra, int'($urandom_range(0, 4)), 8'($urandom_range(0, 255)), ga);
      end
    end

    rom_read(16'h1234, 1000, 8'h55, ga);
    rom_read(16'h2345, 1, 8'h66, ga);

    // asynchronous reset in the middle of a fetch
    @(posedge clk); #1; A = 16'h3000; mreq_n = 1'b0; rd_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst_rom_cs", 32'(rom_cs), 32'd0);
    check("midrst_wait_n", 32'(wait_n), 32'd1);
    check("midrst_dout", 32'(dout), 32'hFF);
    check("midrst_tmo_err", 32'(tmo_err), 32'd0);
    check("midrst_banks", 32'(banks), 32'd0);
    reset_model();
    mreq_n = 1'b1; rd_n = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    rom_read(16'h8010, 1, 8'h24, ga);
    check("post_rst_addr", 32'(ga), 32'h04010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/jtpang_rombank.md
Name: jtpang_rombank

Overview:
- Parametrised ROM banking and fetch controller for the Z80 main CPU.
- Replaces the fixed single 16 KB bank window with NWIN independent sub-windows.
- Each sub-window has its own I/O-written bank register.
- Adds a ROM fetch handshake: it drives a CPU wait line, times out and recovers. It sits between the CPU bus and the SDRAM ROM port, ahead of the decryption stage.

Parameters:
- ROM_AW, 20: ROM byte-address width.
- BANKW, 4: bits per bank register.
- NWIN, 2: sub-windows inside 0x8000–0xBFFF. Legal values are 1, 2 and 4.
- BANK_OFS, 2: page offset added to every bank value, in sub-window-size units.
- BANK_PORT, 2: I/O address (A[4:0]) of window 0's bank register. Window i uses BANK_PORT+i.
- TMO, 255: clock cycles to wait for rom_ok before declaring a timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- A  in  16  CPU address
- mreq_n  in  1  CPU memory request
- iorq_n  in  1  CPU I/O request
- rfsh_n  in  1  CPU refresh
- wr_n  in  1  CPU write strobe
- rd_n  in  1  CPU read strobe
- cpu_dout  in  8  CPU write data
- rom_addr  out  ROM_AW  ROM byte address
- rom_cs  out  1  ROM request
- rom_data  in  8  ROM data
- rom_ok  in  1  ROM data valid
- dout  out  8  latched ROM byte for the CPU
- wait_n  out  1  CPU wait, active low
- tmo_err  out  1  sticky timeout flag
- banks  out  NWIN*BANKW  concatenated bank registers, window 0 in the LSBs

Behaviour:
- Reset values:
  - all bank registers 0
  - rom_cs 0, wait_n 1, dout 8'hFF, tmo_err 0
  - FSM in IDLE, timeout counter 0
- ROM decode: romsel = !mreq_n && rfsh_n && A[15:14] != 2'b11.
- Fixed area, A[15]=0: rom_addr = zero-extended A[14:0].
- Banked area, A[15:14]=2'b10:
  - WAW = 14 - log2(NWIN).
  - Window index w = A[13:WAW].
  - rom_addr = ((bank[w] + BANK_OFS) << WAW) | A[WAW-1:0].
  - The sum is computed in ROM_AW bits and truncated; there is no wrap error.
- Bank write: !iorq_n && !wr_n && A[4:0] == BANK_PORT+i loads bank[i] <= cpu_dout[BANKW-1:0] on the next clk.
  - A write during FETCH takes effect for the next access only.
  - rom_addr is registered at FETCH entry and held for the whole fetch.
- FSM states:
  - IDLE: on romsel, register rom_addr, assert rom_cs, drop wait_n in the same cycle (combinational on romsel), clear the counter, go to FETCH.
  - FETCH: rom_ok in the first FETCH cycle is ignored, because it is stale.
    - rom_ok from the second cycle on: dout <= rom_data, rom_cs 0, wait_n 1, go to VALID.
    - Counter reaching TMO: dout <= 8'hFF, tmo_err <= 1, rom_cs 0, wait_n 1, go to VALID.
  - VALID: hold dout.
    - mreq_n high returns to IDLE.
    - A change while romsel is still true returns to IDLE. The new access starts the cycle after.
- mreq_n rising during FETCH: abort to IDLE, drop rom_cs, release wait_n, leave dout unchanged.
- Refresh cycles and the 0xC000–0xFFFF area never assert rom_cs or wait_n.
- tmo_err clears only on rst.
- Reset mid-FETCH: everything returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: JTPANG_ROMBANK_CACHE_EN.
- When defined, a one-entry cache holds the last fetched rom_addr and data, plus a valid bit.
  - A romsel whose computed rom_addr hits the valid entry goes straight from IDLE to VALID with the cached byte.
  - On a hit, rom_cs is never asserted and wait_n stays 1.
  - Any bank write, rst or timeout invalidates the entry.
- When undefined, every access goes through FETCH and there is no cache logic.

Test Plan:
- Reset, then write 3 to port 2 and 5 to port 3 (NWIN=2). Read 0x8010 -> rom_addr = ((3+2)<<13)|0x10 = 0x0A010. Read 0xA010 -> rom_addr = ((5+2)<<13)|0x10 = 0x0E010. banks = 8'h53.
- Read 0x4123 with rom_ok asserted 3 cycles after rom_cs -> wait_n low for exactly those cycles; dout = rom_data sampled on rom_ok; rom_addr = 0x04123.
- rom_ok held high continuously from before the request -> not accepted in FETCH cycle 1; completion on cycle 2.
- rom_ok never asserted, TMO=255 -> after 255 cycles dout = 8'hFF, tmo_err = 1, wait_n = 1; tmo_err stays high until rst.
- mreq_n deasserted mid-FETCH, then a bank write during a subsequent FETCH -> abort to IDLE with dout unchanged; the in-flight rom_addr is unchanged, and the next access uses the new bank.
- With JTPANG_ROMBANK_CACHE_EN, read 0x8000 twice -> second read has no rom_cs and wait_n stays 1. A bank write in between forces a refetch.
